// File: rtl/c7b_biu_rd_arb.sv
// c7b_biu_rd_arb: N-channel AXI read front end, one AR outstanding, R beats routed to the granted client.
// Define C7B_BIU_RD_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module c7b_biu_rd_arb #(
  parameter int NCH       = 3,
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int IDW       = 4,
  parameter int ID_BASE   = 0,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    cl_req,
  input  logic [NCH*AW-1:0] cl_addr,
  input  logic [NCH-1:0]    cl_single,
  input  logic [NCH-1:0]    cl_cancel,
  output logic [NCH-1:0]    cl_ack,
  output logic [NCH-1:0]    cl_data_valid,
  output logic [NCH-1:0]    cl_data_last,
  output logic [NCH-1:0]    cl_fault,
  output logic [DW-1:0]     cl_data,
  output logic              arvalid,
  input  logic              arready,
  output logic [IDW-1:0]    arid,
  output logic [AW-1:0]     araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [IDW-1:0]    rid,
  input  logic [DW-1:0]     rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast
);
  localparam int GW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [2:0] ASZ = 3'($clog2(DW/8));
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state, state_nx;
  logic [GW-1:0] gnt, sel;
  logic [NCH-1:0] onehot, dv;
  logic [4:0] cnt;
  logic any_req, grant, beat, ovr, fin, flt, canc, canc_q;
`ifdef C7B_BIU_RD_RR_EN
  logic [GW-1:0] ptr;
  // Later iterations overwrite earlier ones, so the channel right after ptr wins.
  always_comb begin
    sel = '0;
    any_req = 1'b0;
    for (int k = NCH-1; k >= 0; k--)
      if (cl_req[(int'(ptr)+1+k)%NCH]) begin
        sel = GW'((int'(ptr)+1+k)%NCH);
        any_req = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ptr <= GW'(NCH-1);
    else if (arvalid && arready) ptr <= gnt;
`else
  always_comb begin
    sel = '0;
    any_req = 1'b0;
    for (int k = NCH-1; k >= 0; k--)
      if (cl_req[k]) begin
        sel = GW'(k);
        any_req = 1'b1;
      end
  end
`endif
  assign grant   = state == IDLE && any_req;
  assign arvalid = state == AR;
  assign rready  = state == R;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign onehot  = NCH'(1) << gnt;
  assign cl_ack  = (arvalid && arready) ? onehot : '0;
  assign beat    = rready && rvalid && rid == arid;
  // A beat beyond arlen+1 without rlast is the overrun beat: faulted and forced last.
  assign ovr     = {3'd0, cnt} == arlen + 8'd1;
  assign fin     = rlast || ovr;
  assign flt     = rresp != 2'b00 || ovr || (rlast && {3'd0, cnt} != arlen);
  assign canc    = state != IDLE && (canc_q || cl_cancel[gnt]);
  assign dv      = (beat && !canc) ? onehot : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any_req ? AR : IDLE;
      AR:      state_nx = arready ? R : AR;
      R:       state_nx = (beat && fin) ? IDLE : R;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      gnt           <= '0;
      araddr        <= '0;
      arid          <= '0;
      arlen         <= '0;
      arsize        <= '0;
      arburst       <= '0;
      cnt           <= '0;
      canc_q        <= 1'b0;
      cl_data_valid <= '0;
      cl_data_last  <= '0;
      cl_fault      <= '0;
      cl_data       <= '0;
    end else begin
      cl_data_valid <= dv;
      cl_data_last  <= dv & {NCH{fin}};
      cl_fault      <= dv & {NCH{flt}};
      if (dv != '0) cl_data <= rdata;
      if (grant) begin
        gnt     <= sel;
        araddr  <= cl_addr[sel*AW +: AW];
        arid    <= IDW'(ID_BASE) + IDW'(sel);
        arlen   <= cl_single[sel] ? 8'd0 : 8'(BURST_LEN-1);
        arsize  <= ASZ;
        arburst <= cl_single[sel] ? 2'b01 : 2'b10;
        cnt     <= '0;
        canc_q  <= 1'b0;
      end else begin
        canc_q <= canc;
        if (beat) cnt <= cnt + 5'd1;
      end
    end
endmodule
